// File: rtl/cga_alu_dbr_seq_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cga_alu_dbr_seq_if
// Purpose  : Bundle of the request/data/handshake signals between the
//            requesting units, the DBR consumer and the DBR load sequencer.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
interface cga_alu_dbr_seq_if #(
  parameter int WIDTH = 16
);
  logic [2:0]       REQ;
  logic [WIDTH-1:0] D0_15_0;
  logic [WIDTH-1:0] D1_15_0;
  logic [WIDTH-1:0] D2_15_0;
  logic             STALL;
  logic             DBRTAKE;
  logic [WIDTH-1:0] CD_15_0;
  logic             LDDBRN;
  logic [2:0]       GNT;
  logic             DBRVALID;
  logic [1:0]       DBRSRC;

  // Requesters and the DBR consumer.
  modport master (
    output REQ, D0_15_0, D1_15_0, D2_15_0, STALL, DBRTAKE,
    input  CD_15_0, LDDBRN, GNT, DBRVALID, DBRSRC
  );

  // The sequencer itself.
  modport slave (
    input  REQ, D0_15_0, D1_15_0, D2_15_0, STALL, DBRTAKE,
    output CD_15_0, LDDBRN, GNT, DBRVALID, DBRSRC
  );
endinterface
`default_nettype wire

// File: rtl/cga_alu_dbr_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : cga_alu_dbr_seq
// Purpose  : DBR load sequencer. Round-robin arbitration of three CD-bus
//            sources (memory, I/O, literal) into the single data bus
//            register, driving the registered CD word and active-low
//            LDDBRN strobe, and tracking DBR occupancy against DBRTAKE.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module cga_alu_dbr_seq #(
  parameter int WIDTH = 16
) (
  input  wire logic         ALUCLK,
  input  wire logic         RESET,
  cga_alu_dbr_seq_if.slave  bus
);

  // LOADING is the only real state: the cycle in which LDDBRN is low.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t           state_q;
  logic             lddbrn_q;
  logic [2:0]       gnt_q;
  logic [WIDTH-1:0] cd_q;
  logic             valid_q;
  logic [1:0]       dbrsrc_q;
  logic [1:0]       src_q;
  logic [1:0]       ptr_q;

  logic [2:0]       elig_d;
  logic             grant_d;
  logic [1:0]       sel_d;
  logic [1:0]       ptr_d;
  logic [2:0]       onehot_d;
  logic [WIDTH-1:0] data_d;
  logic [1:0]       cand1;
  logic [1:0]       cand2;

  // Modulo-3 increment of a requester index.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Bit of a 3-bit vector selected by a requester index.
  function automatic logic bit3(input logic [2:0] v, input logic [1:0] i);
    logic r;
    case (i)
      2'd0:    r = v[0];
      2'd1:    r = v[1];
      2'd2:    r = v[2];
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // A requester still holding REQ during its own grant pulse is not eligible.
  assign elig_d = bus.REQ & ~gnt_q;

  // Round-robin pick starting at PTR, plus the overall grant decision.
  always_comb begin
    cand1    = inc3(ptr_q);
    cand2    = inc3(cand1);
    sel_d    = ptr_q;
    if (bit3(elig_d, ptr_q)) begin
      sel_d = ptr_q;
    end else if (bit3(elig_d, cand1)) begin
      sel_d = cand1;
    end else begin
      sel_d = cand2;
    end
    // Never start a load while one is in flight or while the DBR holds an
    // unconsumed word that is not being taken at this edge.
    grant_d  = !bus.STALL && (state_q == ST_IDLE) &&
               (!valid_q || bus.DBRTAKE) && (elig_d != 3'b000);
    ptr_d    = inc3(sel_d);
    onehot_d = 3'b000;
    data_d   = bus.D0_15_0;
    case (sel_d)
      2'd1: begin
        onehot_d = 3'b010;
        data_d   = bus.D1_15_0;
      end
      2'd2: begin
        onehot_d = 3'b100;
        data_d   = bus.D2_15_0;
      end
      default: begin
        onehot_d = 3'b001;
        data_d   = bus.D0_15_0;
      end
    endcase
  end

  // Sequencer state, grant/strobe outputs and DBR occupancy tracking.
  always_ff @(posedge ALUCLK) begin
    if (RESET) begin
      state_q  <= ST_IDLE;
      lddbrn_q <= 1'b1;
      gnt_q    <= 3'b000;
      cd_q     <= '0;
      valid_q  <= 1'b0;
      dbrsrc_q <= 2'd0;
      src_q    <= 2'd0;
      ptr_q    <= 2'd0;
    end else begin
      state_q  <= ST_IDLE;
      lddbrn_q <= 1'b1;
      gnt_q    <= 3'b000;

      // The DBR captures CD on the load-complete edge; a take only empties
      // it when no load lands on the same edge.
      if (state_q == ST_LOAD) begin
        valid_q  <= 1'b1;
        dbrsrc_q <= src_q;
      end else if (valid_q && bus.DBRTAKE) begin
        valid_q  <= 1'b0;
      end

      if (grant_d) begin
        state_q  <= ST_LOAD;
        lddbrn_q <= 1'b0;
        gnt_q    <= onehot_d;
        cd_q     <= data_d;
        src_q    <= sel_d;
        ptr_q    <= ptr_d;
      end
    end
  end

  assign bus.CD_15_0  = cd_q;
  assign bus.LDDBRN   = lddbrn_q;
  assign bus.GNT      = gnt_q;
  assign bus.DBRVALID = valid_q;
  assign bus.DBRSRC   = dbrsrc_q;

endmodule
`default_nettype wire

// File: tb/tb_cga_alu_dbr_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_cga_alu_dbr_seq
// Purpose  : Directed self-checking bench for the DBR load sequencer.
// Revision : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_cga_alu_dbr_seq;

  localparam int WIDTH = 16;

  logic ALUCLK = 1'b0;
  logic RESET  = 1'b1;
  int   n_chk  = 0;
  int   n_err  = 0;

  cga_alu_dbr_seq_if #(.WIDTH(WIDTH)) bus ();

  cga_alu_dbr_seq #(.WIDTH(WIDTH)) dut (
    .ALUCLK (ALUCLK),
    .RESET  (RESET),
    .bus    (bus)
  );

  always #5 ALUCLK = ~ALUCLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land just after the edge.
  task automatic tick();
    @(posedge ALUCLK);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, 32'(bus.GNT), 32'h0);
    chk({tag, "_ld"},  32'(bus.LDDBRN), 32'h1);
  endtask

  logic [2:0]  rr_gnt [8];
  logic [15:0] rr_cd  [8];

  initial begin
    bus.REQ     = 3'b000;
    bus.D0_15_0 = '0;
    bus.D1_15_0 = '0;
    bus.D2_15_0 = '0;
    bus.STALL   = 1'b0;
    bus.DBRTAKE = 1'b0;

    // ---- reset state, then single load from memory
    tick(); tick();
    chk("rst_ld",  32'(bus.LDDBRN), 32'h1);
    chk("rst_gnt", 32'(bus.GNT), 32'h0);
    chk("rst_cd",  32'(bus.CD_15_0), 32'h0);
    chk("rst_val", 32'(bus.DBRVALID), 32'h0);
    chk("rst_src", 32'(bus.DBRSRC), 32'h0);
    RESET = 1'b0;
    bus.REQ = 3'b001; bus.D0_15_0 = 16'h1234;
    tick();
    chk("t1_gnt", 32'(bus.GNT), 32'h1);
    chk("t1_ld",  32'(bus.LDDBRN), 32'h0);
    chk("t1_cd",  32'(bus.CD_15_0), 32'h1234);
    chk("t1_val0", 32'(bus.DBRVALID), 32'h0);
    bus.REQ = 3'b000;
    tick();
    chk("t1_val", 32'(bus.DBRVALID), 32'h1);
    chk("t1_src", 32'(bus.DBRSRC), 32'h0);
    chk_idle("t1_after");

    // ---- full DBR blocks grants until taken
    bus.REQ = 3'b010; bus.D1_15_0 = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_idle("t2_block");
      chk("t2_val", 32'(bus.DBRVALID), 32'h1);
    end
    bus.DBRTAKE = 1'b1;
    tick();
    chk("t2_gnt", 32'(bus.GNT), 32'h2);
    chk("t2_cd",  32'(bus.CD_15_0), 32'h5555);
    chk("t2_taken", 32'(bus.DBRVALID), 32'h0);
    bus.DBRTAKE = 1'b0; bus.REQ = 3'b000;
    tick();
    chk("t2_val", 32'(bus.DBRVALID), 32'h1);
    chk("t2_src", 32'(bus.DBRSRC), 32'h1);

    // ---- round robin with continuous take
    RESET = 1'b1; tick(); RESET = 1'b0;
    rr_gnt = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
    rr_cd  = '{16'hA, 16'hA, 16'hB, 16'hB, 16'hC, 16'hC, 16'hA, 16'hA};
    bus.REQ = 3'b111; bus.DBRTAKE = 1'b1;
    bus.D0_15_0 = 16'hA; bus.D1_15_0 = 16'hB; bus.D2_15_0 = 16'hC;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("t3_gnt%0d", i), 32'(bus.GNT), 32'(rr_gnt[i]));
      chk($sformatf("t3_ld%0d", i), 32'(bus.LDDBRN), (rr_gnt[i] != 3'b000) ? 32'h0 : 32'h1);
      chk($sformatf("t3_cd%0d", i), 32'(bus.CD_15_0), 32'(rr_cd[i]));
    end
    bus.REQ = 3'b000; bus.DBRTAKE = 1'b0;
    chk("t3_val", 32'(bus.DBRVALID), 32'h1);
    chk("t3_src", 32'(bus.DBRSRC), 32'h0);

    // ---- STALL blocks grants but not a load in flight
    bus.DBRTAKE = 1'b1; tick(); bus.DBRTAKE = 1'b0;
    chk("t4_empty", 32'(bus.DBRVALID), 32'h0);
    bus.STALL = 1'b1; bus.REQ = 3'b100; bus.D2_15_0 = 16'hC0DE;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("t4_stall");
    end
    bus.STALL = 1'b0;
    tick();
    chk("t4_gnt", 32'(bus.GNT), 32'h4);
    chk("t4_cd",  32'(bus.CD_15_0), 32'hC0DE);
    bus.STALL = 1'b1;
    tick();
    chk("t4_val", 32'(bus.DBRVALID), 32'h1);
    chk("t4_src", 32'(bus.DBRSRC), 32'h2);
    chk_idle("t4_after");
    bus.STALL = 1'b0; bus.REQ = 3'b000;

    // ---- reset during the load cycle cancels it and restarts PTR
    bus.DBRTAKE = 1'b1; tick(); bus.DBRTAKE = 1'b0;
    bus.REQ = 3'b010; bus.D1_15_0 = 16'h7777;
    tick();
    chk("t5_gnt", 32'(bus.GNT), 32'h2);
    bus.REQ = 3'b000; RESET = 1'b1;
    tick();
    RESET = 1'b0;
    chk("t5_ld",  32'(bus.LDDBRN), 32'h1);
    chk("t5_val", 32'(bus.DBRVALID), 32'h0);
    chk("t5_cd",  32'(bus.CD_15_0), 32'h0);
    tick();
    chk("t5_noval", 32'(bus.DBRVALID), 32'h0);
    bus.REQ = 3'b110; bus.D1_15_0 = 16'h0B0B; bus.D2_15_0 = 16'h0C0C;
    tick();
    chk("t5_ptr_gnt", 32'(bus.GNT), 32'h2);
    chk("t5_ptr_cd",  32'(bus.CD_15_0), 32'h0B0B);
    bus.REQ = 3'b000;
    tick();
    chk("t5_val2", 32'(bus.DBRVALID), 32'h1);
    chk("t5_src2", 32'(bus.DBRSRC), 32'h1);

    // ---- DBRTAKE while empty is ignored; withdrawn request never granted
    bus.DBRTAKE = 1'b1; tick(); bus.DBRTAKE = 1'b0;
    tick();
    chk("t6_empty", 32'(bus.DBRVALID), 32'h0);
    bus.DBRTAKE = 1'b1; tick(); bus.DBRTAKE = 1'b0;
    chk("t6_val", 32'(bus.DBRVALID), 32'h0);
    chk("t6_src", 32'(bus.DBRSRC), 32'h1);
    chk("t6_cd",  32'(bus.CD_15_0), 32'h0B0B);
    chk_idle("t6_take");
    bus.STALL = 1'b1; bus.REQ = 3'b001; bus.D0_15_0 = 16'hDEAD;
    tick(); chk_idle("t6_stall0");
    tick(); chk_idle("t6_stall1");
    bus.REQ = 3'b000; bus.STALL = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle("t6_drop");
      chk("t6_drop_val", 32'(bus.DBRVALID), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
